// File: rtl/transpose_write_loader.sv
// Transposing write loader: collects DATA_WIDTH narrow words into a tile,
// then drains IN_WIDTH transposed rows into consecutive array addresses.

// One tile row: bit lane j of every accepted word lands at column idx.
module tile_row #(
  parameter int DATA_WIDTH = 160,
  parameter int KW         = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [KW-1:0]         idx,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] row_q
);
  // Tile storage is intentionally unreset; it is always fully rewritten before a drain.
  always_ff @(posedge clk) begin
    if (we) row_q[idx] <= bit_in;
  end
endmodule

module transpose_write_loader #(
  parameter int DATA_WIDTH = 160,
  parameter int HEIGHT     = 128,
  parameter int ADDR_LEN   = $clog2(HEIGHT),
  parameter int IN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_LEN-1:0]   base_addr,
  output logic                  wen,
  output logic [ADDR_LEN-1:0]   waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  tile_done
);
  localparam int KW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t                              state;
  logic                                live;
  logic [KW-1:0]                       wcnt;
  logic [CW-1:0]                       ccnt;
  logic [ADDR_LEN-1:0]                 base_q;
  logic [IN_WIDTH-1:0][DATA_WIDTH-1:0] row_q;
  logic [DATA_WIDTH-1:0]               row0_nxt;
  logic                                accept;
  logic                                last_word;
  logic [ADDR_LEN-1:0]                 base_nxt;
  logic [ADDR_LEN-1:0]                 addr_inc;

  // live holds in_ready low until the first edge after reset release.
  assign in_ready  = live && (state == FILL);
  assign accept    = in_valid && in_ready;
  assign last_word = accept && (wcnt == KW'(DATA_WIDTH - 1));
  // base is sampled with word 0; for a one-word tile it is needed the same cycle.
  assign base_nxt  = (wcnt == '0) ? base_addr : base_q;
  assign addr_inc  = (waddr == ADDR_LEN'(HEIGHT - 1)) ? '0 : waddr + 1'b1;

  // Row 0 as it will look after the final word lands, so the first write
  // can leave on the same edge that captures the last word.
  always_comb begin
    row0_nxt                 = row_q[0];
    row0_nxt[DATA_WIDTH-1]   = in_data[0];
  end

  genvar g;
  generate
    for (g = 0; g < IN_WIDTH; g++) begin : g_lane
      tile_row #(.DATA_WIDTH(DATA_WIDTH), .KW(KW)) u_row (
        .clk    (clk),
        .we     (accept),
        .idx    (wcnt),
        .bit_in (in_data[g]),
        .row_q  (row_q[g])
      );
    end
  endgenerate

  // FILL/DRAIN control with registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      live      <= 1'b0;
      wcnt      <= '0;
      ccnt      <= '0;
      base_q    <= '0;
      wen       <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      live      <= 1'b1;
      tile_done <= 1'b0;
      case (state)
        FILL: begin
          wen <= 1'b0;
          if (accept) begin
            if (wcnt == '0) base_q <= base_addr;
            if (last_word) begin
              wcnt  <= '0;
              ccnt  <= '0;
              state <= DRAIN;
              busy  <= 1'b1;
              wen   <= 1'b1;
              waddr <= base_nxt;
              wdata <= row0_nxt;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (ccnt == CW'(IN_WIDTH - 1)) begin
            state     <= FILL;
            busy      <= 1'b0;
            wen       <= 1'b0;
            tile_done <= 1'b1;
            ccnt      <= '0;
          end else begin
            ccnt  <= ccnt + 1'b1;
            waddr <= addr_inc;
            wdata <= row_q[ccnt + 1'b1];
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
